// File: rtl/imem_pkg.sv
// Shared types and sizing helpers for the instruction-memory responder.
package imem_pkg;

    localparam int WORD_W = 32;

    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
        logic              err;
    } rsp_t;

    typedef struct packed {
        logic valid;
        rsp_t rsp;
    } stage_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side request/response channel plus redirect flush.
interface imem_responder_if;
    import imem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [WORD_W-1:0] req_addr;
    logic              flush;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_data;
    logic [WORD_W-1:0] rsp_addr;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );

endinterface

// File: rtl/imem_responder_rsp_fifo.sv
// Response buffer; a clear that coincides with a push keeps only the pushed entry.
module rsp_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic push,
    input  rsp_t push_data,
    input  logic pop,
    output rsp_t pop_data,
    output logic empty,
    output logic full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    rsp_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign wr_idx   = clear ? '0 : wr_ptr;
    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= push ? next_ptr('0) : '0;
            rd_ptr <= '0;
            count  <= {{(CNT_W-1){1'b0}}, push};
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/imem_responder.sv
// Loadable instruction RAM behind a fixed-latency read pipeline with credit-based
// response buffering and redirect flush.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int RSP_DEPTH   = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    imem_responder_if.slave                     bus,
    input  logic                                ld_en,
    input  logic [index_width(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [WORD_W-1:0]                   ld_data
);

    localparam int IDX_W  = index_width(DEPTH_WORDS);
    localparam int CRED_W = $clog2(RSP_DEPTH + 1);
    localparam int PIPE_N = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RSP_DEPTH);
    localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);

    logic [WORD_W-1:0] ram [DEPTH_WORDS];
    logic [CRED_W-1:0] credits_used;
    logic [IDX_W-1:0]  req_idx;
    logic              req_err;
    logic              accept;
    logic              pop;
    logic              fifo_push;
    logic              fifo_empty;
    logic              fifo_full;
    stage_t            st_p0;
    stage_t            st_last;
    rsp_t              fifo_out;

    assign req_idx = bus.req_addr[IDX_W+1:2];
    assign req_err = (bus.req_addr[1:0] != 2'b00) ||
                     (bus.req_addr[WORD_W-1:IDX_W+2] != '0);

    assign bus.req_ready = (credits_used < CRED_MAX);
    assign accept        = bus.req_valid & bus.req_ready;
    assign bus.rsp_valid = ~fifo_empty & ~bus.flush;
    assign pop           = bus.rsp_valid & bus.rsp_ready;

    // Program load port; a same-cycle read sees the old word.
    always_ff @(posedge clock) begin
        if (ld_en) ram[ld_addr] <= ld_data;
    end

    // Stage p0: accepted request, RAM read skipped for errored requests
    always_comb begin
        st_p0.valid    = accept;
        st_p0.rsp.addr = bus.req_addr;
        st_p0.rsp.err  = req_err;
        st_p0.rsp.data = req_err ? '0 : ram[req_idx];
    end

    generate
        if (LATENCY > 1) begin : gen_pipe
            logic vld_p [PIPE_N];
            rsp_t rsp_p [PIPE_N];

            // Stages p1..pN: flush kills older entries, but the request accepted
            // in the flush cycle enters p1 as the head of the new path.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < PIPE_N; k++) vld_p[k] <= 1'b0;
                end else begin
                    vld_p[0] <= st_p0.valid;
                    for (int k = 1; k < PIPE_N; k++) vld_p[k] <= vld_p[k-1] & ~bus.flush;
                end
            end

            always_ff @(posedge clock) begin
                rsp_p[0] <= st_p0.rsp;
                for (int k = 1; k < PIPE_N; k++) rsp_p[k] <= rsp_p[k-1];
            end

            assign st_last = {vld_p[PIPE_N-1], rsp_p[PIPE_N-1]};
        end else begin : gen_direct
            assign st_last = st_p0;
        end
    endgenerate

    // With a single stage the last stage is the fresh request, which survives flush.
    assign fifo_push = st_last.valid & (~bus.flush | (LATENCY == 1));

    rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (bus.flush),
        .push      (fifo_push),
        .push_data (st_last.rsp),
        .pop       (pop),
        .pop_data  (fifo_out),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.rsp_data = fifo_empty ? '0   : fifo_out.data;
    assign bus.rsp_addr = fifo_empty ? '0   : fifo_out.addr;
    assign bus.rsp_err  = fifo_empty ? 1'b0 : fifo_out.err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credits_used <= '0;
        end else if (bus.flush) begin
            credits_used <= accept ? CRED_ONE : '0;
        end else if (accept && !pop) begin
            credits_used <= credits_used + CRED_ONE;
        end else if (!accept && pop) begin
            credits_used <= credits_used - CRED_ONE;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(fifo_push && fifo_full && !bus.flush));

    a_credit_range: assert property (@(posedge clock) disable iff (!reset)
        credits_used <= CRED_MAX);

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the fetch stage. Accepts word-fetch requests over a valid/ready channel, reads a loadable on-chip instruction RAM through a fixed-latency read pipeline, and returns responses in order through a small buffered valid/ready channel with backpressure. A flush input discards all in-flight and buffered responses when fetch redirects on a branch or jump. A separate load port writes the program image into the RAM.

## Interface
- DEPTH_WORDS, 256: instruction RAM size in 32-bit words; power of two.
- LATENCY, 2: read pipeline stages from request accept to response-buffer write; must be at least 1.
- RSP_DEPTH, 4: response buffer entries; must be at least LATENCY+1.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request present
- req_ready  out  1  responder can accept a request this cycle
- req_addr  in  32  byte address of the requested instruction word
- flush  in  1  discard all outstanding and buffered responses
- rsp_valid  out  1  response available
- rsp_ready  in  1  fetch consumes the response
- rsp_data  out  32  instruction word, or 0 on error
- rsp_addr  out  32  req_addr of the request this response answers
- rsp_err  out  1  request was misaligned or out of range
- ld_en  in  1  program-load write strobe
- ld_addr  in  log2(DEPTH_WORDS)  word index to write
- ld_data  in  32  word to write

## Operation
- A request is accepted when req_valid and req_ready are both high. The RAM word index is req_addr[log2(DEPTH_WORDS)+1:2].
- Errors:
  - If req_addr[1:0] is not 0, or req_addr is at or above DEPTH_WORDS*4, the response carries rsp_err=1 and rsp_data=0.
  - No RAM read occurs for an errored request, but it still occupies a pipeline slot and a buffer slot.
- Pipeline: each LATENCY stage holds valid, addr, data and err. The final stage writes into the response FIFO.
- Ordering: responses leave in strict acceptance order, with exactly one response per accepted request.
- Credits:
  - A credit counter tracks pipeline occupancy plus FIFO occupancy. Its range is 0..RSP_DEPTH.
  - req_ready = (credits_used < RSP_DEPTH).
  - The counter increments on accept and decrements on rsp_valid & rsp_ready. When both happen in the same cycle, it is unchanged.
  - The FIFO therefore never overflows, and the pipeline never stalls.
- Flush:
  - In the cycle flush is high, all pipeline valids, FIFO contents and the credit counter are cleared at the next edge.
  - rsp_valid is forced to 0 combinationally in the flush cycle, so no handshake completes.
  - A request accepted in the flush cycle is kept. It is the first request of the new path and enters the pipeline with credits_used=1.
- Load port:
  - ld_en writes ld_data into RAM[ld_addr] at the edge.
  - If a read of the same word is accepted in the same cycle, the read returns the old word.
  - Loads are independent of flush and credits.
- Reset:
  - Clears pipeline valids, the FIFO and the credit counter.
  - RAM contents are not reset.
  - Output values during reset: req_ready=1, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0.
  - Reset asserted mid-operation drops every outstanding request.

## Timing
- A request accepted in cycle t gives rsp_valid=1 in cycle t+LATENCY at the earliest, when the FIFO is empty.
- Throughput is one response per cycle when rsp_ready is held high and RSP_DEPTH >= LATENCY+1.
- While rsp_valid=1 and rsp_ready=0, rsp_data, rsp_addr and rsp_err hold stable.
- req_ready depends only on registered state. It has no combinational path from req_valid or rsp_ready.
- rsp_valid is registered FIFO state gated by flush.

## Structure
- Package imem_pkg holds:
  - the word width constant (32);
  - the derived index width function (clog2);
  - the pipeline-stage struct/typedef {valid, addr, data, err}.
- Sub-module rsp_fifo: a synchronous FIFO, RSP_DEPTH entries wide enough for {addr, data, err}, with push, pop, clear, empty and full ports. Its full output is used for assertions only.
- The top level holds the RAM, the pipeline, the credit counter and the error checks.

## Test plan
- Load and stream (LATENCY=2): load words 0..7 with 0xAC030000..0x08000002, then hold rsp_ready=1 and request addresses 0x00..0x1C on consecutive cycles. Required: 8 responses with matching data/addr, the first in cycle t+2, and no gaps.
- Backpressure: hold rsp_ready=0 and issue requests. Required: req_ready drops after 4 accepts. Raising rsp_ready then drains all 4 in order with no loss or duplicates.
- Errors: request 0x00000006 and 0x00000400 (DEPTH_WORDS=256). Required: both return rsp_err=1, rsp_data=0, rsp_addr echoed.
- Flush with redirect: 3 requests in flight, then flush together with a request to 0x08. Required: only the 0x08 response appears, and credits_used=1 after the flush edge.
- Load/read collision: ld_en to word 2 with 0xDEADBEEF while a read of 0x08 is accepted. Required: the response is the old word, and the next read of 0x08 returns 0xDEADBEEF.
- Async reset mid-stream: assert reset between edges with the FIFO non-empty. Required: outputs immediately show rsp_valid=0 and req_ready=1, and RAM contents are preserved.
